// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage.
//   DATA_W : default register data width
//   RN_W   : default register-number width
//   NREG   : number of architectural registers tracked by the scoreboard
//   state_e: operand-fetch FSM states
package operand_fetch_pkg;
    localparam int DATA_W = 16;
    localparam int RN_W   = 4;
    localparam int NREG   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2
    } state_e;
endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy-register scoreboard: one bit per register, set when an instruction
// that writes it leaves fetch, cleared on write-back or on a flushed bundle.
//   clk, rst_n        : clock, async active-low reset
//   set_en / set_rn   : mark register busy
//   clr_en / clr_rn   : write-back clear
//   kill_en / kill_rn : clear for a flushed in-flight bundle
//   busy              : registered busy vector
module reg_scoreboard #(
    parameter int RN_W = operand_fetch_pkg::RN_W,
    parameter int NREG = operand_fetch_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [RN_W-1:0] set_rn,
    input  logic            clr_en,
    input  logic [RN_W-1:0] clr_rn,
    input  logic            kill_en,
    input  logic [RN_W-1:0] kill_rn,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied last so a same-edge set and clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en)  busy_d[clr_rn]  = 1'b0;
        if (kill_en) busy_d[kill_rn] = 1'b0;
        if (set_en)  busy_d[set_rn]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: accepts one decoded instruction, reads its sources
// from the register file once no source/destination is busy, and holds the
// operand bundle until downstream takes it.
//   in_*        : decoded instruction handshake and fields
//   rn1..3/read3: register-file read addresses / third-port enable
//   A, B, C     : register-file combinational read data
//   wb_valid/rd : write-back retiring this cycle
//   flush       : abandon held instruction
//   out_*/op_*  : operand bundle handshake and payload
//   stall_cnt   : saturating hazard-stall cycle count
//
// state    | meaning
// ST_IDLE  | ready for a new instruction
// ST_FETCH | holding instruction, waiting for sources to be free
// ST_OUT   | operand bundle presented, waiting for out_ready
module operand_fetch #(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int RN_W   = operand_fetch_pkg::RN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RN_W-1:0]   in_rs1,
    input  logic [RN_W-1:0]   in_rs2,
    input  logic [RN_W-1:0]   in_rs3,
    input  logic              in_use3,
    input  logic [RN_W-1:0]   in_rd,
    input  logic              in_wb,
    output logic [RN_W-1:0]   rn1,
    output logic [RN_W-1:0]   rn2,
    output logic [RN_W-1:0]   rn3,
    output logic              read3,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    input  logic              wb_valid,
    input  logic [RN_W-1:0]   wb_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_c,
    output logic [RN_W-1:0]   op_rd,
    output logic              op_wb,
    output logic [15:0]       stall_cnt
);
    import operand_fetch_pkg::*;

    localparam int NR = 2 ** RN_W;

    state_e            state_q, state_d;
    logic              init_q, init_d;
    logic [RN_W-1:0]   h_rs1_q, h_rs1_d, h_rs2_q, h_rs2_d, h_rs3_q, h_rs3_d;
    logic [RN_W-1:0]   h_rd_q, h_rd_d;
    logic              h_use3_q, h_use3_d, h_wb_q, h_wb_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [RN_W-1:0]   op_rd_q, op_rd_d;
    logic              op_wb_q, op_wb_d;
    logic [15:0]       stall_q, stall_d;

    logic [NR-1:0]     busy;
    logic              hazard;
    logic              set_en, kill_en;

    reg_scoreboard #(.RN_W(RN_W), .NREG(NR)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_rn  (h_rd_q),
        .clr_en  (wb_valid),
        .clr_rn  (wb_rd),
        .kill_en (kill_en),
        .kill_rn (op_rd_q),
        .busy    (busy)
    );

    assign hazard = busy[h_rs1_q] | busy[h_rs2_q] |
                    (busy[h_rs3_q] & h_use3_q) | (busy[h_rd_q] & h_wb_q);

    always_comb begin
        state_d  = state_q;
        init_d   = 1'b1;
        h_rs1_d  = h_rs1_q;
        h_rs2_d  = h_rs2_q;
        h_rs3_d  = h_rs3_q;
        h_use3_d = h_use3_q;
        h_rd_d   = h_rd_q;
        h_wb_d   = h_wb_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_c_d   = op_c_q;
        op_rd_d  = op_rd_q;
        op_wb_d  = op_wb_q;
        stall_d  = stall_q;
        in_ready = 1'b0;
        rn1      = '0;
        rn2      = '0;
        rn3      = '0;
        read3    = 1'b0;
        set_en   = 1'b0;
        kill_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // init_q keeps in_ready low until the first edge after reset.
                in_ready = init_q;
                if (!flush && in_valid && init_q) begin
                    h_rs1_d  = in_rs1;
                    h_rs2_d  = in_rs2;
                    h_rs3_d  = in_rs3;
                    h_use3_d = in_use3;
                    h_rd_d   = in_rd;
                    h_wb_d   = in_wb;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rn1   = h_rs1_q;
                rn2   = h_rs2_q;
                rn3   = h_rs3_q;
                read3 = h_use3_q;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (hazard) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else begin
                    op_a_d  = A;
                    op_b_d  = B;
                    op_c_d  = h_use3_q ? C : '0;
                    op_rd_d = h_rd_q;
                    op_wb_d = h_wb_q;
                    set_en  = h_wb_q;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (flush) begin
                    kill_en = op_wb_q;
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            init_q   <= 1'b0;
            h_rs1_q  <= '0;
            h_rs2_q  <= '0;
            h_rs3_q  <= '0;
            h_use3_q <= 1'b0;
            h_rd_q   <= '0;
            h_wb_q   <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_c_q   <= '0;
            op_rd_q  <= '0;
            op_wb_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            h_rs1_q  <= h_rs1_d;
            h_rs2_q  <= h_rs2_d;
            h_rs3_q  <= h_rs3_d;
            h_use3_q <= h_use3_d;
            h_rd_q   <= h_rd_d;
            h_wb_q   <= h_wb_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_c_q   <= op_c_d;
            op_rd_q  <= op_rd_d;
            op_wb_q  <= op_wb_d;
            stall_q  <= stall_d;
        end
    end

    assign out_valid = (state_q == ST_OUT);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_c      = op_c_q;
    assign op_rd     = op_rd_q;
    assign op_wb     = op_wb_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rs3, in_rd;
    logic        in_use3, in_wb;
    logic [3:0]  rn1, rn2, rn3;
    logic        read3;
    logic [15:0] A, B, C;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] op_a, op_b, op_c;
    logic [3:0]  op_rd;
    logic        op_wb;
    logic [15:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_use3(in_use3), .in_rd(in_rd), .in_wb(in_wb),
        .rn1(rn1), .rn2(rn2), .rn3(rn3), .read3(read3),
        .A(A), .B(B), .C(C),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .op_rd(op_rd), .op_wb(op_wb), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rs3,
                         input logic use3, input logic [3:0] rd, input logic wb);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs2 = rs2; in_rs3 = rs3;
        in_use3 = use3; in_rd = rd; in_wb = wb;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_rd = '0;
        in_use3 = 1'b0; in_wb = 1'b0;
        A = '0; B = '0; C = '0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; out_ready = 1'b0;

        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_rn1", rn1, 0);
        chk("rst_op_a", op_a, 0);

        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Scenario 1: two sources, no third
        A = 16'hABCD; B = 16'h3579; C = 16'h1111;
        issue(4'd2, 4'd4, 4'd0, 1'b0, 4'd3, 1'b0);
        chk("s1_fetch_rn1", rn1, 2);
        chk("s1_fetch_rn2", rn2, 4);
        chk("s1_fetch_read3", read3, 0);
        chk("s1_fetch_in_ready", in_ready, 0);
        chk("s1_fetch_out_valid", out_valid, 0);
        tick();
        chk("s1_out_valid", out_valid, 1);
        chk("s1_op_a", op_a, 16'hABCD);
        chk("s1_op_b", op_b, 16'h3579);
        chk("s1_op_c", op_c, 16'h0000);
        chk("s1_out_rn1", rn1, 0);
        chk("s1_out_in_ready", in_ready, 0);
        drain();
        chk("s1_idle_out_valid", out_valid, 0);
        chk("s1_idle_in_ready", in_ready, 1);

        // Scenario 2: third source
        A = 16'h0101; B = 16'h0202; C = 16'h2468;
        issue(4'd6, 4'd7, 4'd1, 1'b1, 4'd0, 1'b0);
        chk("s2_read3", read3, 1);
        chk("s2_rn3", rn3, 1);
        tick();
        chk("s2_op_c", op_c, 16'h2468);
        drain();

        // Scenario 3: RAW hazard on r15, released by write-back
        issue(4'd1, 4'd2, 4'd0, 1'b0, 4'hF, 1'b1);
        tick();
        chk("s3_i1_op_wb", op_wb, 1);
        drain();
        A = 16'hBEEF; B = 16'h0000;
        issue(4'hF, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("s3_stall1", stall_cnt, 1);
        chk("s3_stall_out_valid", out_valid, 0);
        chk("s3_stall_rn1", rn1, 4'hF);
        tick();
        chk("s3_stall2", stall_cnt, 2);
        wb_valid = 1'b1; wb_rd = 4'hF;
        tick();
        wb_valid = 1'b0;
        chk("s3_wb_edge_out_valid", out_valid, 0);
        chk("s3_stall3", stall_cnt, 3);
        tick();
        chk("s3_capture_out_valid", out_valid, 1);
        chk("s3_op_a", op_a, 16'hBEEF);
        chk("s3_stall_final", stall_cnt, 3);
        drain();

        // Scenario 4: same-edge set and clear of r5 keeps it busy
        issue(4'd0, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1);
        wb_valid = 1'b1; wb_rd = 4'd5;
        tick();
        wb_valid = 1'b0;
        chk("s4_out_valid", out_valid, 1);
        drain();
        issue(4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("s4_busy5_stall", stall_cnt, 4);
        chk("s4_busy5_out_valid", out_valid, 0);
        wb_valid = 1'b1; wb_rd = 4'd5;
        tick();
        wb_valid = 1'b0;
        tick();
        chk("s4_release_out_valid", out_valid, 1);
        chk("s4_stall_final", stall_cnt, 5);
        drain();

        // Scenario 5: backpressure then flush in OUT clears busy[op_rd]
        A = 16'h1234; B = 16'h5678;
        issue(4'd3, 4'd4, 4'd0, 1'b0, 4'd9, 1'b1);
        tick();
        A = 16'h0000; B = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            chk("s5_hold_out_valid", out_valid, 1);
            chk("s5_hold_op_a", op_a, 16'h1234);
            chk("s5_hold_op_b", op_b, 16'h5678);
            chk("s5_hold_in_ready", in_ready, 0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s5_flush_out_valid", out_valid, 0);
        chk("s5_flush_in_ready", in_ready, 1);
        A = 16'h7777;
        issue(4'd9, 4'd0, 4'd0, 1'b0, 4'd9, 1'b0);
        tick();
        chk("s5_r9_free_out_valid", out_valid, 1);
        chk("s5_r9_free_op_a", op_a, 16'h7777);
        chk("s5_r9_free_stall", stall_cnt, 5);
        drain();

        // Scenario 6: reset while in FETCH
        issue(4'd2, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("s6_fetch_rn1", rn1, 2);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_out_valid", out_valid, 0);
        chk("s6_rst_in_ready", in_ready, 0);
        chk("s6_rst_rn1", rn1, 0);
        chk("s6_rst_stall", stall_cnt, 0);
        chk("s6_rst_op_a", op_a, 0);
        chk("s6_rst_op_wb", op_wb, 0);
        tick(); tick();
        chk("s6_rst_hold_out_valid", out_valid, 0);
        chk("s6_rst_hold_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("s6_release_in_ready", in_ready, 1);
        chk("s6_release_out_valid", out_valid, 0);
        tick();
        chk("s6_no_bundle", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter RN_W, default 4, register-number width (16 registers).
REQ-003 SHALL have these ports; one clock, reset asynchronous active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction fields valid.
- in_ready  out  1  block can accept an instruction.
- in_rs1, in_rs2, in_rs3  in  RN_W  source register numbers.
- in_use3  in  1  third source used.
- in_rd  in  RN_W  destination register number.
- in_wb  in  1  instruction writes in_rd.
- rn1, rn2, rn3  out  RN_W  register-file read addresses.
- read3  out  1  register-file third-port enable.
- A, B, C  in  DATA_W  register-file combinational read data.
- wb_valid  in  1  write-back retiring this cycle (same cycle as reg_wr).
- wb_rd  in  RN_W  register being written back.
- flush  in  1  synchronous abandon of the held instruction.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- op_a, op_b, op_c  out  DATA_W  captured operands.
- op_rd  out  RN_W  destination, passed through.
- op_wb  out  1  write flag, passed through.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-004 SHALL implement states IDLE, FETCH, OUT.
REQ-005 In IDLE, in_ready SHALL be 1; on in_valid&in_ready, fields latch into holding registers and the state moves to FETCH.
REQ-006 In FETCH, rn1/rn2/rn3 SHALL present the held rs1/rs2/rs3 and read3 SHALL equal the held use3; outside FETCH, rn1/rn2/rn3 and read3 SHALL be 0.
REQ-007 A hazard SHALL exist in FETCH when busy[rs1], busy[rs2], busy[rs3]&use3, or busy[rd]&wb is set, using the registered busy vector.
REQ-008 In FETCH with no hazard, A/B/C SHALL be captured into op_a/op_b/op_c (op_c = 0 when use3 = 0) and the state moves to OUT; with a hazard, FETCH SHALL be held and stall_cnt incremented, saturating at 16'hFFFF.
REQ-009 Minimum latency: accept at edge N, capture at edge N+1, out_valid = 1 from edge N+1 until the handshake.
REQ-010 In OUT, out_valid SHALL be 1 and op_* stable until out_valid&out_ready, after which the state returns to IDLE (one dead cycle before the next accept).
REQ-011 The capture edge SHALL set busy[rd] when wb = 1.
REQ-012 wb_valid SHALL clear busy[wb_rd] at the edge; a cleared bit SHALL first unblock FETCH in the following cycle, when the register file already holds the new value.
REQ-013 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-014 flush SHALL return the state to IDLE, drop out_valid the next cycle, and take priority over all handshakes; a flush in OUT with op_wb = 1 SHALL clear busy[op_rd]; a flush in FETCH SHALL leave busy unchanged.
REQ-015 out_valid SHALL never be 1 while in_ready is 1.

Reset
REQ-016 While rst_n = 0: state IDLE, busy all 0, stall_cnt 0, op_a/op_b/op_c/op_rd/op_wb 0, out_valid 0, rn1/rn2/rn3/read3 0, and in_ready 0.
REQ-017 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-018 Reset mid-operation SHALL discard the held instruction with no bundle emitted.

Structure
REQ-019 A shared package SHALL hold DATA_W, RN_W, NREG = 16, and the state enum.
REQ-020 The busy vector with set/clear/priority logic SHALL be a sub-module reg_scoreboard.

Verification
REQ-021 Bench scenarios:
- Reset, rs1 = 2, rs2 = 4, use3 = 0, A = ABCD, B = 3579 -> out_valid at edge N+1, op_a = ABCD, op_b = 3579, op_c = 0000, rn1 = 2 only in FETCH.
- use3 = 1, rs3 = 1, C = 2468 -> read3 = 1 in FETCH, op_c = 2468.
- Instruction 1 with rd = F, wb = 1, then instruction 2 with rs1 = F -> FETCH stalls, stall_cnt counts; wb_valid with wb_rd = F -> capture one cycle later.
- Same edge: wb_rd = 5 clear and capture setting rd = 5 -> busy[5] remains 1.
- out_ready held 0 for 3 cycles -> op_* stable, in_ready = 0; flush in OUT -> IDLE, busy[op_rd] cleared.
- rst_n low in FETCH -> out_valid stays 0, in_ready 0 until release, all outputs 0.
